// File: rtl/car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : car_motion_controller
// Description : Cabin motion and door sequencer for a 4-floor elevator car.
//               Tick-counted travel and door phases driven by manager requests.
// Revision    : 1.0 - initial release
// ============================================================================

module car_motion_controller #(
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 6,
    parameter int TOP_FLOOR    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UDRequest,
    input  logic       OCRequest,
    input  logic       NoStopRequest,
    output logic [1:0] CurrentFloor,
    output logic       UDIn,
    output logic       Delay,
    output logic       Stop,
    output logic       DoorOpen,
    output logic       Moving
);

    localparam logic [15:0] C_TRAVEL_LAST = 16'(TRAVEL_TICKS - 1);
    localparam logic [15:0] C_DOOR_LAST   = 16'(DOOR_TICKS - 1);
    localparam logic [1:0]  C_TOP_FLOOR   = 2'(TOP_FLOOR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_MOVE   = 3'd2,
        S_ARRIVE = 3'd3,
        S_CHECK  = 3'd4,
        S_DOOR   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  floor_q, floor_d;
    logic        udin_q,  udin_d;
    logic [15:0] cnt_q,   cnt_d;

    logic        w_at_top;
    logic        w_at_bottom;

    assign w_at_top    = (floor_q == C_TOP_FLOOR);
    assign w_at_bottom = (floor_q == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            floor_q <= 2'd0;
            udin_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            udin_q  <= udin_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        udin_d   = udin_q;
        cnt_d    = cnt_q;
        Delay    = 1'b0;
        Stop     = 1'b0;
        DoorOpen = 1'b0;
        Moving   = 1'b0;

        case (state_q)
            S_IDLE: begin
                Stop = 1'b1;
                if (NoStopRequest) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                udin_d = UDRequest;
                // A restart toward the wall the car already sits at is a no-op.
                if ((UDRequest && w_at_top) || (!UDRequest && w_at_bottom)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 16'd0;
                    state_d = S_MOVE;
                end
            end

            S_MOVE: begin
                Moving = 1'b1;
                if (cnt_q == C_TRAVEL_LAST) begin
                    cnt_d   = 16'd0;
                    floor_d = udin_q ? (floor_q + 2'd1) : (floor_q - 2'd1);
                    state_d = S_ARRIVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_ARRIVE: begin
                Delay   = 1'b1;
                state_d = S_CHECK;
            end

            S_CHECK: begin
                if (OCRequest) begin
                    cnt_d   = 16'd0;
                    state_d = S_DOOR;
                end else if ((udin_q && w_at_top) || (!udin_q && w_at_bottom)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 16'd0;
                    state_d = S_MOVE;
                end
            end

            S_DOOR: begin
                DoorOpen = 1'b1;
                if (cnt_q == C_DOOR_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CurrentFloor = floor_q;
    assign UDIn         = udin_q;

endmodule

`default_nettype wire

// File: tb/tb_car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_motion_controller
// Description : Directed bench; arrival strobes are scoreboarded against a queue.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_car_motion_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       UDRequest;
    logic       OCRequest;
    logic       NoStopRequest;
    logic [1:0] CurrentFloor;
    logic       UDIn;
    logic       Delay;
    logic       Stop;
    logic       DoorOpen;
    logic       Moving;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected arrivals as {UDIn, CurrentFloor}
    logic [2:0] exp_q[$];

    car_motion_controller #(
        .TRAVEL_TICKS(8),
        .DOOR_TICKS  (6),
        .TOP_FLOOR   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .UDRequest    (UDRequest),
        .OCRequest    (OCRequest),
        .NoStopRequest(NoStopRequest),
        .CurrentFloor (CurrentFloor),
        .UDIn         (UDIn),
        .Delay        (Delay),
        .Stop         (Stop),
        .DoorOpen     (DoorOpen),
        .Moving       (Moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every arrival strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            check("exclusive", int'($countones({Delay, DoorOpen, Moving, Stop}) <= 1), 1);
            if (Delay) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_arrival", {29'd0, UDIn, CurrentFloor}, 7);
                end else begin
                    check("arrival", {29'd0, UDIn, CurrentFloor}, {29'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Issue a restart; caller is just past a negedge, car in IDLE.
    task automatic start(input logic ud, input logic oc);
        UDRequest     = ud;
        OCRequest     = oc;
        NoStopRequest = 1'b1;
        @(posedge clk);
        #1 NoStopRequest = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int doors);
        int k;
        doors = 0;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (DoorOpen) doors++;
            if (Stop) break;
        end
        if (k == budget) check("idle_timeout", 0, 1);
    endtask

    task automatic go_one_floor(input logic ud, input logic [1:0] dest);
        int d;
        exp_q.push_back({ud, dest});
        start(ud, 1'b1);
        wait_idle(60, d);
        check("one_floor_dest", CurrentFloor, dest);
        check("one_floor_door", d, 6);
    endtask

    initial begin
        int mv, dr, dly_cnt, first_door;
        int dly_at[3];
        int d;

        reset         = 1'b1;
        UDRequest     = 1'b0;
        OCRequest     = 1'b0;
        NoStopRequest = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", {28'd0, CurrentFloor, Stop, Delay, Moving}, {28'd0, 2'd0, 1'b1, 1'b0, 1'b0});
        end

        // One floor up with door
        exp_q.push_back({1'b1, 2'd1});
        start(1'b1, 1'b1);
        mv = 0; dr = 0; dly_cnt = 0; dly_at[0] = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (Moving) mv++;
            if (DoorOpen) dr++;
            if (Delay) begin dly_at[0] = k; dly_cnt++; end
            if (k == 1) check("start_quiet", {28'd0, Stop, Moving, Delay, DoorOpen}, 0);
            if (k == 11) check("check_quiet", {28'd0, Stop, Moving, Delay, DoorOpen}, 0);
            if (k == 18) check("stop_after_door", Stop, 1);
        end
        check("move_cycles", mv, 8);
        check("door_cycles", dr, 6);
        check("delay_cycle", dly_at[0], 10);
        check("delay_count", dly_cnt, 1);

        // Back down to floor 0, no door
        exp_q.push_back({1'b0, 2'd0});
        start(1'b0, 1'b0);
        wait_idle(40, d);
        check("down_to0_floor", CurrentFloor, 0);
        check("down_to0_door", d, 0);

        // Express run 0 -> 3, door only at the top
        exp_q.push_back({1'b1, 2'd1});
        exp_q.push_back({1'b1, 2'd2});
        exp_q.push_back({1'b1, 2'd3});
        start(1'b1, 1'b0);
        dly_cnt = 0; first_door = 0; dr = 0;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            if (Delay) begin
                if (dly_cnt < 3) dly_at[dly_cnt] = k;
                dly_cnt++;
                if (dly_cnt == 3) OCRequest = 1'b1;
            end
            if (DoorOpen) begin
                dr++;
                if (first_door == 0) first_door = k;
            end
            if (k == 38) check("express_stop", Stop, 1);
        end
        OCRequest = 1'b0;
        check("express_delays", dly_cnt, 3);
        check("express_first", dly_at[0], 10);
        check("express_gap1", dly_at[1] - dly_at[0], 10);
        check("express_gap2", dly_at[2] - dly_at[1], 10);
        check("express_door_at", first_door, 32);
        check("express_door_len", dr, 6);
        check("express_floor", CurrentFloor, 3);

        // Restart toward the wall at floor 3
        start(1'b1, 1'b0);
        mv = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (Moving) mv++;
            if (k == 1) check("wall3_start", Stop, 0);
            if (k == 2) check("wall3_idle", Stop, 1);
        end
        check("wall3_moving", mv, 0);
        check("wall3_floor", CurrentFloor, 3);
        check("wall3_udin", UDIn, 1);

        // Down 3 -> 0 without stopping
        exp_q.push_back({1'b0, 2'd2});
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd0});
        start(1'b0, 1'b0);
        wait_idle(60, d);
        check("down3_floor", CurrentFloor, 0);

        // Restart toward the wall at floor 0
        start(1'b0, 1'b0);
        mv = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (Moving) mv++;
            if (k == 2) check("wall0_idle", Stop, 1);
        end
        check("wall0_moving", mv, 0);
        check("wall0_floor", CurrentFloor, 0);

        // Reset in the 4th MOVE cycle between floors 1 and 2
        go_one_floor(1'b1, 2'd1);
        start(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("mid_move", Moving, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_floor", CurrentFloor, 0);
        check("rst_stop", Stop, 1);
        check("rst_moving", Moving, 0);
        reset = 1'b0;
        dly_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (Delay) dly_cnt++;
        end
        check("rst_no_delay", dly_cnt, 0);

        // Down from floor 2, passing 1, ending at 0
        go_one_floor(1'b1, 2'd1);
        go_one_floor(1'b1, 2'd2);
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd0});
        start(1'b0, 1'b0);
        wait_idle(40, d);
        check("down2_door", d, 0);
        check("down2_floor", CurrentFloor, 0);
        check("down2_udin", UDIn, 0);
        check("down2_stop", Stop, 1);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
